// File: rtl/multicycle_main_control.sv
// -----------------------------------------------------------------------------
// multicycle_main_control
//
// Main control FSM for a multi-cycle RISC-V datapath (lw, sw, R-type, beq).
// It sequences fetch / decode / execute / memory / writeback steps, drives
// every datapath strobe and mux select, and counts retired instructions.
//
// Handshake: mem_ready is a single-cycle completion strobe from memory. In
// FETCH, MEM_RD and MEM_WR the FSM holds its state and keeps its request
// asserted until a cycle with mem_ready=1. That cycle completes the access,
// and the FSM advances on the following clock edge. mem_ready is ignored in
// every other state.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   opcode[6:0]    instruction[6:0] from the instruction register
//   mem_ready      memory completes the current read/write this cycle
//   alu_op[1:0]    00 add, 01 sub, 10 funct decode
//   alu_src_a[1:0] 00 PC, 01 old PC, 10 rs1
//   alu_src_b[1:0] 00 rs2, 01 constant 4, 10 immediate
//   pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
//   ir_write, reg_write, mem_to_reg   datapath strobes / selects
//   illegal        one-cycle pulse in DECODE on an unsupported opcode
//   state[3:0]     current state encoding (debug)
//   instret        retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_main_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        ALU_WB   = 4'd7,
        BRANCH   = 4'd8
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t state_q;

    // Next-state and retired-instruction counter. Encodings 9-15 fall to the
    // default arm and recover to FETCH without touching instret.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            instret <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (mem_ready) state_q <= DECODE;
                end
                DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_q <= MEM_ADDR;
                        OP_RTYPE:          state_q <= EXEC;
                        OP_BRANCH:         state_q <= BRANCH;
                        default:           state_q <= FETCH;
                    endcase
                end
                MEM_ADDR: begin
                    state_q <= (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    if (mem_ready) state_q <= MEM_WB;
                end
                MEM_WB: begin
                    state_q <= FETCH;
                    instret <= instret + CNT_W'(1);
                end
                MEM_WR: begin
                    if (mem_ready) begin
                        state_q <= FETCH;
                        instret <= instret + CNT_W'(1);
                    end
                end
                EXEC: begin
                    state_q <= ALU_WB;
                end
                ALU_WB: begin
                    state_q <= FETCH;
                    instret <= instret + CNT_W'(1);
                end
                BRANCH: begin
                    state_q <= FETCH;
                    instret <= instret + CNT_W'(1);
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign state = state_q;

    // Output decode. Moore in state, except ir_write/pc_write in FETCH
    // (qualified by mem_ready) and illegal in DECODE (qualified by opcode).
    // rst gates everything so no strobe fires in a reset cycle.
    always_comb begin
        alu_op        = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        illegal       = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    // Branch target (old PC + imm) lands in ALUOut.
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    illegal   = !(opcode == OP_LOAD  || opcode == OP_STORE ||
                                  opcode == OP_RTYPE || opcode == OP_BRANCH);
                end
                MEM_ADDR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                EXEC: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                end
                ALU_WB: begin
                    reg_write = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 2'b10;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
module tb_multicycle_main_control;

    localparam int CNT_W = 4;
    localparam int W     = 20 + CNT_W;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // clock / reset block
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [6:0]       opcode = 7'd0;
    logic             mem_ready = 1'b0;
    logic [1:0]       alu_op, alu_src_a, alu_src_b;
    logic             pc_write, pc_write_cond, pc_source, i_or_d;
    logic             mem_read, mem_write, ir_write, reg_write, mem_to_reg, illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] instret;

    always #5 clk = ~clk;

    multicycle_main_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .state(state), .instret(instret)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    // Expected outputs from the state/output table:
    // {alu_op, src_a, src_b, pc_write, pc_write_cond, pc_source, i_or_d,
    //  mem_read, mem_write, ir_write, reg_write, mem_to_reg, illegal, state, instret}
    function automatic logic [W-1:0] expect_vec(input logic r, input logic mr,
                                                input logic [6:0] op, input logic [3:0] st,
                                                input logic [CNT_W-1:0] cnt);
        logic [1:0] aop, sa, sb;
        logic pw, pwc, ps, iod, mrd, mwr, irw, rw, m2r, ill;
        aop = 2'b00; sa = 2'b00; sb = 2'b00;
        pw = 0; pwc = 0; ps = 0; iod = 0; mrd = 0; mwr = 0; irw = 0; rw = 0; m2r = 0; ill = 0;
        if (!r) begin
            case (st)
                4'd0: begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
                4'd1: begin
                    sa = 2'b01; sb = 2'b10;
                    ill = (op != OP_LW && op != OP_SW && op != OP_R && op != OP_BEQ);
                end
                4'd2: begin sa = 2'b10; sb = 2'b10; end
                4'd3: begin mrd = 1; iod = 1; end
                4'd4: begin rw = 1; m2r = 1; end
                4'd5: begin mwr = 1; iod = 1; end
                4'd6: begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
                4'd7: begin rw = 1; end
                4'd8: begin sa = 2'b10; sb = 2'b00; aop = 2'b01; pwc = 1; ps = 1; end
                default: begin end
            endcase
        end
        return {aop, sa, sb, pw, pwc, ps, iod, mrd, mwr, irw, rw, m2r, ill, st, cnt};
    endfunction

    // driver task: called just after a posedge; drives one cycle of inputs,
    // pushes the expectation, compares at the negedge, returns after next posedge.
    task automatic step(input string tag, input logic r, input logic mr,
                        input logic [6:0] op, input logic [3:0] st,
                        input logic [CNT_W-1:0] cnt);
        logic [W-1:0] exp_v, obs_v;
        rst = r;
        mem_ready = mr;
        opcode = op;
        exp_q.push_back(expect_vec(r, mr, op, st, cnt));
        @(negedge clk);
        obs_v = {alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source,
                 i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
                 illegal, state, instret};
        exp_v = exp_q.pop_front();
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    logic [CNT_W-1:0] cnt;

    initial begin
        // reset: two cycles with rst high, mem_ready high in FETCH (strobes must stay 0)
        @(posedge clk); #1;
        step("reset0", 1, 1, OP_R, 4'd0, 0);
        step("reset1", 1, 1, OP_R, 4'd0, 0);

        // R-type: 0,1,6,7,0
        step("r_fetch",  0, 1, OP_R, 4'd0, 0);
        step("r_decode", 0, 1, OP_R, 4'd1, 0);
        step("r_exec",   0, 1, OP_R, 4'd6, 0);
        step("r_wb",     0, 1, OP_R, 4'd7, 0);
        cnt = 1;

        // lw with two wait cycles in MEM_RD: 0,1,2,3,3,3,4
        step("lw_fetch",  0, 1, OP_LW, 4'd0, cnt);
        step("lw_decode", 0, 1, OP_LW, 4'd1, cnt);
        step("lw_addr",   0, 1, OP_LW, 4'd2, cnt);
        step("lw_rd_w0",  0, 0, OP_LW, 4'd3, cnt);
        step("lw_rd_w1",  0, 0, OP_LW, 4'd3, cnt);
        step("lw_rd",     0, 1, OP_LW, 4'd3, cnt);
        step("lw_wb",     0, 1, OP_LW, 4'd4, cnt);
        cnt++;

        // sw with three wait cycles in FETCH, then 1,2,5
        step("sw_fetch_w0", 0, 0, OP_SW, 4'd0, cnt);
        step("sw_fetch_w1", 0, 0, OP_SW, 4'd0, cnt);
        step("sw_fetch_w2", 0, 0, OP_SW, 4'd0, cnt);
        step("sw_fetch",    0, 1, OP_SW, 4'd0, cnt);
        step("sw_decode",   0, 1, OP_SW, 4'd1, cnt);
        step("sw_addr",     0, 1, OP_SW, 4'd2, cnt);
        step("sw_wr",       0, 1, OP_SW, 4'd5, cnt);
        cnt++;

        // beq: 0,1,8
        step("beq_fetch",  0, 1, OP_BEQ, 4'd0, cnt);
        step("beq_decode", 0, 1, OP_BEQ, 4'd1, cnt);
        step("beq_branch", 0, 1, OP_BEQ, 4'd8, cnt);
        cnt++;

        // illegal opcode: pulse in DECODE, back to FETCH, no retire
        step("ill_fetch",  0, 1, OP_BAD, 4'd0, cnt);
        step("ill_decode", 0, 1, OP_BAD, 4'd1, cnt);

        // lw interrupted by reset in MEM_RD
        step("lwr_fetch",  0, 1, OP_LW, 4'd0, cnt);
        step("lwr_decode", 0, 1, OP_LW, 4'd1, cnt);
        step("lwr_addr",   0, 1, OP_LW, 4'd2, cnt);
        step("lwr_rst",    1, 1, OP_LW, 4'd3, cnt);
        cnt = 0;

        // 16 R-type instructions: counter reaches 15 then wraps to 0;
        // mem_ready is randomised where it must be ignored
        for (int i = 0; i < 16; i++) begin
            step("wrap_fetch",  0, 1, OP_R, 4'd0, cnt);
            step("wrap_decode", 0, 1'($urandom_range(0, 1)), OP_R, 4'd1, cnt);
            step("wrap_exec",   0, 1'($urandom_range(0, 1)), OP_R, 4'd6, cnt);
            step("wrap_wb",     0, 1'($urandom_range(0, 1)), OP_R, 4'd7, cnt);
            cnt++;
        end
        step("wrap_zero", 0, 0, OP_R, 4'd0, cnt);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multi-cycle RISC-V datapath. It decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback steps.
- It produces the 2-bit alu_op consumed by the ALU control decoder: 00 = add, 01 = subtract, 10 = decode funct3/funct7.
- It drives all datapath strobes and muxes.
- It waits on a memory ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter instret (wraps modulo 2^CNT_W)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
opcode  input  7  instruction[6:0] from instruction register
mem_ready  input  1  memory completes current read/write this cycle
alu_op  output  2  to ALU control: 00 add, 01 sub, 10 funct-decode
alu_src_a  output  2  00 PC, 01 old PC, 10 rs1 register
alu_src_b  output  2  00 rs2 register, 01 constant 4, 10 immediate
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (beq)
pc_source  output  1  0 ALU result, 1 ALUOut register
i_or_d  output  1  memory address: 0 PC, 1 ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  load instruction register
reg_write  output  1  register file write
mem_to_reg  output  1  writeback source: 0 ALUOut, 1 memory data register
illegal  output  1  one-cycle pulse on unsupported opcode
state  output  4  current state encoding (debug)
instret  output  CNT_W  retired-instruction count

Behaviour:
- State register updates on posedge clk only.
- Reset: rst=1 at a clock edge sets state=FETCH(0) and instret=0.
- While rst is high, every strobe output (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal) is forced 0 and all mux selects/alu_op are 00/0.
- Reset asserted mid-instruction abandons the instruction; no strobe fires in the reset cycle.
- Outputs are Moore functions of state, except the ones noted as qualified by mem_ready.
- Default for every output in every state is 0 / 00; only the listed signals change.
- States and outputs:
  - FETCH(0): mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=0. ir_write and pc_write equal mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE(1): alu_src_a=01, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEM_ADDR
    - 0110011 -> EXEC
    - 1100011 -> BRANCH
    - any other -> FETCH, with illegal=1 for this cycle.
  - MEM_ADDR(2): alu_src_a=10, alu_src_b=10, alu_op=00. Next is MEM_RD for opcode 0000011, else MEM_WR.
  - MEM_RD(3): mem_read=1, i_or_d=1. Hold until mem_ready=1, then MEM_WB.
  - MEM_WB(4): reg_write=1, mem_to_reg=1. Then FETCH.
  - MEM_WR(5): mem_write=1, i_or_d=1. Hold until mem_ready=1, then FETCH.
  - EXEC(6): alu_src_a=10, alu_src_b=00, alu_op=10. Then ALU_WB.
  - ALU_WB(7): reg_write=1, mem_to_reg=0. Then FETCH.
  - BRANCH(8): alu_src_a=10, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1. Then FETCH.
- Encodings 9-15 are unreachable; if entered they return to FETCH next cycle with all strobes 0 and no instret change.
- opcode is sampled in DECODE and MEM_ADDR only. The instruction register is stable from the cycle after FETCH completes.
- instret increments by 1 on the clock edge leaving a completing state:
  - MEM_WB
  - MEM_WR with mem_ready=1
  - ALU_WB
  - BRANCH
- Illegal instructions do not increment instret. instret wraps from all-ones to 0.
- Latency with mem_ready held 1:
  - lw 5 cycles
  - sw 4 cycles
  - R-type 4 cycles
  - beq 3 cycles
  - illegal 2 cycles
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_ready is ignored in all other states.

Test Plan:
- Reset for 2 cycles, release with mem_ready=1 and opcode=0110011 -> state 0,1,6,7,0. alu_op=10 only in EXEC. reg_write=1 only in ALU_WB. instret=1 after 4 cycles.
- lw (0000011), mem_ready=1 except 2 low cycles in MEM_RD -> state 0,1,2,3,3,3,4,0. mem_to_reg=1 with reg_write in MEM_WB. 7 cycles total. instret +1.
- sw (0100011) with mem_ready low 3 cycles in FETCH -> FETCH held 4 cycles, ir_write/pc_write pulse once. Then 1,2,5,0. mem_write=1 one cycle. reg_write never 1.
- beq (1100011) -> state 0,1,8,0. In BRANCH: alu_op=01, pc_write_cond=1, pc_source=1, alu_src_a=10, alu_src_b=00.
- opcode 1111111 -> illegal=1 for exactly one cycle in DECODE, next state 0, instret unchanged. Then reset asserted during MEM_RD of a following lw -> next state 0, no reg_write, instret=0.
- CNT_W=4: retire 16 R-type instructions -> instret reads 15 then wraps to 0.
